run_launcher: RTL and testbench
===============================

// Module: run_launcher
// PURPOSE
//  Host-side initiator for the processor's req/done run protocol. Holds the core in reset,
//  releases it, raises req, waits for done and measures run length in cycles. Repeats for
//  N back-to-back runs. Sits between the host/bench control logic and top_level.
// PARAMETERS
//  RESET_CYCLES  5        cycles core_reset is held high before each run (>=1)
//  CNT_W         32       width of cycle counter / cycles output
//  RUN_W         4        width of run count and run index
//  TIMEOUT       100000   WAIT_DONE cycle limit (used only with LAUNCH_TIMEOUT_EN)
// PORTS
//  clk           in   1      system clock, all logic on posedge
//  reset         in   1      asynchronous, active-low
//  start         in   1      sampled in IDLE; begins a batch when runs_in != 0
//  runs_in       in   RUN_W  number of runs in batch, latched on accepted start
//  abort         in   1      synchronous abort of the batch, any state
//  busy          out  1      high in every state except IDLE
//  core_reset    out  1      active-high reset driven to top_level
//  core_req      out  1      run request driven to top_level
//  core_done     in   1      done from top_level
//  result_valid  out  1      one-cycle pulse per finished run
//  result_cycles out  CNT_W  run length, valid with result_valid
//  result_idx    out  RUN_W  0-based run index, valid with result_valid
//  result_tmo    out  1      run ended by timeout, valid with result_valid
//  batch_done    out  1      one-cycle pulse when batch ends (normal, timeout or abort)
// BEHAVIOUR
//  Reset (reset=0): state IDLE; core_reset=1, core_req=0, busy=0, result_valid=0,
//   result_cycles=0, result_idx=0, result_tmo=0, batch_done=0. Counters cleared.
//  IDLE: core_reset=1, core_req=0. start=1 && runs_in!=0 -> latch runs_in, idx=0, HOLD_RST.
//   start with runs_in==0 ignored (no batch_done).
//  HOLD_RST: core_reset=1 for exactly RESET_CYCLES cycles, then -> REQ.
//  REQ: core_reset=0, core_req=1, one cycle; cycle counter cleared -> WAIT_DONE.
//  WAIT_DONE: core_reset=0, core_req held 1. core_done=1 -> REPORT with cycles=counter
//   (done in first WAIT_DONE cycle reports 0); else counter+1, saturating at all-ones.
//  REPORT: one cycle; core_req=0, core_reset=1; result_valid=1 with cycles/idx/tmo.
//   idx==runs-1 or tmo=1 -> IDLE, batch_done=1 same cycle; else idx+1 -> HOLD_RST.
//  Result outputs hold last values until the next REPORT.
//  core_done ignored outside WAIT_DONE (stale done after reset is not a completion).
//  abort=1 in any non-IDLE state: next cycle IDLE, core_req=0, core_reset=1, batch_done=1,
//   no result_valid; abort in IDLE ignored. abort has priority over core_done/timeout.
//  start while busy ignored. reset mid-run: immediate return to reset values.
//  Latency: start accepted -> core_req high = RESET_CYCLES+1 cycles.
// CONFIGURATION
//  LAUNCH_TIMEOUT_EN defined: in WAIT_DONE, counter==TIMEOUT-1 with core_done=0 -> REPORT
//   with result_tmo=1, result_cycles=TIMEOUT; batch terminates (batch_done=1).
//   core_done in the same cycle wins (tmo=0).
//  Not defined: no timeout logic; WAIT_DONE waits indefinitely; result_tmo tied 0.
// TESTING
//  1 Hold reset=0 4 cycles -> all outputs at reset values, core_reset=1, busy=0.
//  2 start, runs_in=1, done model asserts 20 cycles after core_req -> core_req high
//    6 cycles after start; result_valid once, cycles=19, idx=0, tmo=0; batch_done same cycle.
//  3 runs_in=3, done latencies 3/7/0 -> three result_valid pulses, cycles 2/6/0 (instant done
//    reports 0), idx 0/1/2, RESET_CYCLES of core_reset=1 before each core_req.
//  4 core_done stuck high from IDLE, runs_in=1 -> no result before core_req; cycles=0.
//  5 abort asserted 10 cycles into WAIT_DONE of run 1 of 3 -> core_req low next cycle,
//    batch_done=1, no result_valid; following start runs normally.
//  6 LAUNCH_TIMEOUT_EN, TIMEOUT=50, done never -> result_tmo=1, cycles=50, batch ends;
//    without macro, still busy after 1000 cycles; reset=0 mid-wait -> IDLE immediately.

Source files
------------

// File: rtl/run_launcher.sv
// run_launcher: host-side initiator for the core req/done run protocol (hold reset, request, time the run).
// Optional WAIT_DONE timeout is compiled in when the macro LAUNCH_TIMEOUT_EN is defined.
module run_launcher #(
    parameter int unsigned RESET_CYCLES = 5,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned RUN_W        = 4,
    parameter int unsigned TIMEOUT      = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [RUN_W-1:0] runs_in,
    input  logic             abort,
    output logic             busy,
    output logic             core_reset,
    output logic             core_req,
    input  logic             core_done,
    output logic             result_valid,
    output logic [CNT_W-1:0] result_cycles,
    output logic [RUN_W-1:0] result_idx,
    output logic             result_tmo,
    output logic             batch_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD_RST,
        S_REQ,
        S_WAIT_DONE,
        S_REPORT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [RUN_W-1:0] runs;
    logic [RUN_W-1:0] idx;
    logic             abort_q;
    logic             start_ok;
    logic             abort_ok;
    logic             last_run;
    logic             tmo_hit;

    assign start_ok = start && (runs_in != '0);
    assign abort_ok = abort && (state != S_IDLE);
    assign last_run = (idx == runs - 1'b1) || result_tmo;

`ifdef LAUNCH_TIMEOUT_EN
    assign tmo_hit = (cnt == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign tmo_hit        = 1'b0;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt    = state;
        busy         = (state != S_IDLE);
        core_reset   = 1'b1;
        core_req     = 1'b0;
        result_valid = 1'b0;
        batch_done   = abort_q;
        unique case (state)
            S_IDLE:      if (start_ok) state_nxt = S_HOLD_RST;
            S_HOLD_RST:  if (cnt == CNT_W'(RESET_CYCLES - 1)) state_nxt = S_REQ;
            S_REQ: begin
                core_reset = 1'b0;
                core_req   = 1'b1;
                state_nxt  = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                core_reset = 1'b0;
                core_req   = 1'b1;
                if (core_done || tmo_hit) state_nxt = S_REPORT;
            end
            S_REPORT: begin
                result_valid = 1'b1;
                batch_done   = last_run && !abort;
                state_nxt    = last_run ? S_IDLE : S_HOLD_RST;
            end
            default:     state_nxt = S_IDLE;
        endcase
        // Abort overrides every transition, including a completing or timing-out run.
        if (abort_ok) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            runs          <= '0;
            idx           <= '0;
            abort_q       <= 1'b0;
            result_cycles <= '0;
            result_idx    <= '0;
            result_tmo    <= 1'b0;
        end else begin
            abort_q <= abort_ok;
            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start_ok) begin
                        runs <= runs_in;
                        idx  <= '0;
                    end
                end
                S_HOLD_RST:  cnt <= cnt + 1'b1;
                S_REQ:       cnt <= '0;
                S_WAIT_DONE: begin
                    if (!abort && core_done) begin
                        result_cycles <= cnt;
                        result_idx    <= idx;
                        result_tmo    <= 1'b0;
                    end else if (!abort && tmo_hit) begin
                        result_cycles <= CNT_W'(TIMEOUT);
                        result_idx    <= idx;
                        result_tmo    <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_REPORT: begin
                    cnt <= '0;
                    idx <= idx + 1'b1;
                end
                default:     cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_run_launcher.sv
// tb_run_launcher: randomized self-checking bench for run_launcher with a latency-based done model.
// Timeout scenarios switch on LAUNCH_TIMEOUT_EN, matching the DUT build.
module tb_run_launcher;

    localparam int unsigned RC    = 5;
    localparam int unsigned CW    = 32;
    localparam int unsigned RW    = 4;
    localparam int unsigned TMO   = 50;
    localparam int          NEVER = 1 << 30;
`ifdef LAUNCH_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] cycles;
        logic [RW-1:0] idx;
        logic          tmo;
    } res_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          core_done = 1'b0;
    logic [RW-1:0] runs_in = '0;
    logic          busy, core_reset, core_req, result_valid, result_tmo, batch_done;
    logic [CW-1:0] result_cycles;
    logic [RW-1:0] result_idx;

    res_t res_q[$];
    res_t exp_q[$];
    int   lat_q[$];
    int   hold_q[$];
    int   n_pass = 0, n_chk = 0;
    int   bd_cnt = 0, bd_with_rv = 0, req_rises = 0;
    bit   done_stuck = 1'b0, prev_req = 1'b0;
    int   req_age = 0, cur_lat = NEVER, hold_cnt = 0;

    always #5 clk = ~clk;

    run_launcher #(.RESET_CYCLES(RC), .CNT_W(CW), .RUN_W(RW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .runs_in(runs_in), .abort(abort),
        .busy(busy), .core_reset(core_reset), .core_req(core_req), .core_done(core_done),
        .result_valid(result_valid), .result_cycles(result_cycles), .result_idx(result_idx),
        .result_tmo(result_tmo), .batch_done(batch_done)
    );

    // Monitor and core model: observe outputs, then drive done a latency after core_req rises.
    always @(negedge clk) begin
        if (!reset) begin
            prev_req  = 1'b0;
            hold_cnt  = 0;
            req_age   = 0;
            core_done = done_stuck;
        end else begin
            if (result_valid) begin
                res_q.push_back({result_cycles, result_idx, result_tmo});
                if (batch_done) bd_with_rv++;
            end
            if (batch_done) bd_cnt++;
            if (busy && core_reset && !result_valid) hold_cnt++;
            else if (!busy) hold_cnt = 0;
            if (core_req && !prev_req) begin
                hold_q.push_back(hold_cnt);
                hold_cnt = 0;
                req_rises++;
                req_age  = 0;
                cur_lat  = (lat_q.size() != 0) ? lat_q.pop_front() : NEVER;
            end
            prev_req  = core_req;
            core_done = done_stuck || (core_req && req_age >= cur_lat);
            if (core_req) req_age++;
            else          req_age = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference: a run of latency L reports L-1 cycles (0 for L=0); beyond TIMEOUT it times out and ends the batch.
    task automatic build_expect(input int lats[$]);
        exp_q.delete();
        foreach (lats[i]) begin
            res_t r;
            r.idx = RW'(i);
            if (TMO_EN && lats[i] > int'(TMO)) begin
                r.tmo    = 1'b1;
                r.cycles = CW'(TMO);
            end else begin
                r.tmo    = 1'b0;
                r.cycles = (lats[i] == 0) ? '0 : CW'(lats[i] - 1);
            end
            exp_q.push_back(r);
            if (r.tmo) break;
        end
    endtask

    task automatic run_batch(input string name, input int lats[$], input int budget);
        int bd0 = bd_cnt;
        int n   = 0;
        res_q.delete();
        hold_q.delete();
        lat_q   = lats;
        runs_in = RW'(lats.size());
        start   = 1'b1;
        tick();
        start = 1'b0;
        while (bd_cnt == bd0 && n < budget) begin
            tick();
            n++;
        end
        n_chk++;
        if (bd_cnt == bd0) $display("FAIL %s_batch_end: no batch_done within %0d cycles", name, budget);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (4) tick();
        n_chk++;
        if ({busy, core_reset, core_req, result_valid, result_tmo, batch_done} !== 6'b010000)
            $display("FAIL reset_ctl: got %b want 010000",
                     {busy, core_reset, core_req, result_valid, result_tmo, batch_done});
        else n_pass++;
        n_chk++;
        if (result_cycles !== '0 || result_idx !== '0)
            $display("FAIL reset_result: cycles=%0d idx=%0d want 0/0", result_cycles, result_idx);
        else n_pass++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_ignored();
        int bd0 = bd_cnt;
        runs_in = '0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        n_chk++;
        if (busy !== 1'b0 || bd_cnt != bd0)
            $display("FAIL idle_ignore: busy=%b batch_done pulses=%0d want 0/0", busy, bd_cnt - bd0);
        else n_pass++;
    endtask

    task automatic test_single();
        int n = 1;
        int bd0 = bd_cnt;
        res_q.delete();
        hold_q.delete();
        lat_q   = '{20};
        runs_in = RW'(1);
        start   = 1'b1;
        tick();
        start = 1'b0;
        while (!core_req && n < 50) begin
            tick();
            n++;
        end
        n_chk++;
        if (n != int'(RC) + 1) $display("FAIL single_req_latency: got %0d want %0d", n, RC + 1);
        else n_pass++;
        n = 0;
        while (bd_cnt == bd0 && n < 200) begin
            tick();
            n++;
        end
        n_chk++;
        if (res_q.size() != 1 || bd_with_rv < 1)
            $display("FAIL single_count: results=%0d want 1, batch_done with result=%0d", res_q.size(), bd_with_rv);
        else n_pass++;
        n_chk++;
        if (res_q.size() == 1 && res_q[0] !== {CW'(19), RW'(0), 1'b0})
            $display("FAIL single_result: cycles=%0d idx=%0d tmo=%b want 19/0/0",
                     res_q[0].cycles, res_q[0].idx, res_q[0].tmo);
        else n_pass++;
    endtask

    task automatic test_multi();
        int lats[$] = '{3, 7, 0};
        int bdr0    = bd_with_rv;
        build_expect(lats);
        run_batch("multi", lats, 200);
        n_chk++;
        if (res_q.size() != 3 || bd_with_rv != bdr0 + 1)
            $display("FAIL multi_count: results=%0d want 3, final pulses=%0d want 1", res_q.size(), bd_with_rv - bdr0);
        else n_pass++;
        foreach (exp_q[i]) begin
            n_chk++;
            if (i >= res_q.size() || res_q[i] !== exp_q[i])
                $display("FAIL multi_result[%0d]: got %h want %h", i, (i < res_q.size()) ? res_q[i] : '0, exp_q[i]);
            else n_pass++;
        end
        foreach (hold_q[i]) begin
            n_chk++;
            if (hold_q[i] != int'(RC)) $display("FAIL multi_hold[%0d]: got %0d want %0d", i, hold_q[i], RC);
            else n_pass++;
        end
    endtask

    task automatic test_stuck_done();
        int n = 0;
        int bd0 = bd_cnt;
        res_q.delete();
        lat_q.delete();
        done_stuck = 1'b1;
        tick();
        runs_in = RW'(1);
        start   = 1'b1;
        tick();
        start = 1'b0;
        while (!core_req && n < 50) begin
            tick();
            n++;
        end
        n_chk++;
        if (res_q.size() != 0 || !core_req)
            $display("FAIL stuck_early: results before req=%0d req=%b want 0/1", res_q.size(), core_req);
        else n_pass++;
        n = 0;
        while (bd_cnt == bd0 && n < 50) begin
            tick();
            n++;
        end
        done_stuck = 1'b0;
        n_chk++;
        if (res_q.size() != 1 || res_q[0].cycles !== '0)
            $display("FAIL stuck_result: results=%0d cycles=%0d want 1/0", res_q.size(),
                     (res_q.size() != 0) ? res_q[0].cycles : '1);
        else n_pass++;
        tick();
    endtask

    task automatic test_abort();
        int n = 0;
        int r0 = req_rises;
        res_q.delete();
        lat_q   = '{2, NEVER, 3};
        runs_in = RW'(3);
        start   = 1'b1;
        tick();
        start = 1'b0;
        while (req_rises < r0 + 2 && n < 200) begin
            tick();
            n++;
        end
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++;
        if ({core_req, core_reset, busy, batch_done} !== 4'b0101)
            $display("FAIL abort_next: req/rst/busy/bd=%b want 0101", {core_req, core_reset, busy, batch_done});
        else n_pass++;
        repeat (3) tick();
        n_chk++;
        if (res_q.size() != 1) $display("FAIL abort_results: got %0d want 1", res_q.size());
        else n_pass++;
        lat_q.delete();
        begin
            int l[$] = '{5};
            run_batch("after_abort", l, 100);
        end
        n_chk++;
        if (res_q.size() != 1 || res_q[0] !== {CW'(4), RW'(0), 1'b0})
            $display("FAIL after_abort_result: results=%0d want one run of 4 cycles", res_q.size());
        else n_pass++;
    endtask

    task automatic test_timeout();
`ifdef LAUNCH_TIMEOUT_EN
        int l1[$] = '{NEVER, 1, 1};
        int l2[$] = '{50, 51};
        run_batch("tmo", l1, 200);
        n_chk++;
        if (res_q.size() != 1 || res_q[0] !== {CW'(TMO), RW'(0), 1'b1})
            $display("FAIL tmo_result: results=%0d want single tmo run of %0d", res_q.size(), TMO);
        else n_pass++;
        build_expect(l2);
        run_batch("tmo_edge", l2, 300);
        n_chk++;
        if (res_q.size() != 2 || res_q[0] !== exp_q[0] || res_q[1] !== exp_q[1])
            $display("FAIL tmo_edge: results=%0d want done-wins then tmo", res_q.size());
        else n_pass++;
        lat_q   = '{NEVER};
        runs_in = RW'(1);
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
`else
        lat_q   = '{NEVER};
        runs_in = RW'(1);
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (1000) tick();
        n_chk++;
        if (busy !== 1'b1 || core_req !== 1'b1)
            $display("FAIL no_tmo_wait: busy=%b req=%b want 1/1", busy, core_req);
        else n_pass++;
`endif
        reset = 1'b0;
        #1;
        n_chk++;
        if ({busy, core_reset, core_req, result_valid, result_tmo, batch_done} !== 6'b010000
            || result_cycles !== '0 || result_idx !== '0)
            $display("FAIL midrun_reset: ctl=%b cycles=%0d idx=%0d want 010000/0/0",
                     {busy, core_reset, core_req, result_valid, result_tmo, batch_done}, result_cycles, result_idx);
        else n_pass++;
        lat_q.delete();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            int lats[$];
            int nr = int'($urandom_range(1, 4));
            for (int k = 0; k < nr; k++) lats.push_back(int'($urandom_range(0, TMO_EN ? 60 : 30)));
            build_expect(lats);
            run_batch("rand", lats, 400);
            n_chk++;
            if (res_q.size() != exp_q.size())
                $display("FAIL rand_count[%0d]: got %0d want %0d", b, res_q.size(), exp_q.size());
            else n_pass++;
            foreach (exp_q[i]) begin
                n_chk++;
                if (i >= res_q.size() || res_q[i] !== exp_q[i])
                    $display("FAIL rand_result[%0d.%0d]: got %h want %h", b, i, (i < res_q.size()) ? res_q[i] : '0, exp_q[i]);
                else n_pass++;
            end
            foreach (hold_q[i]) begin
                n_chk++;
                if (hold_q[i] != int'(RC)) $display("FAIL rand_hold[%0d.%0d]: got %0d want %0d", b, i, hold_q[i], RC);
                else n_pass++;
            end
            repeat (2) tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ignored();
        test_single();
        test_multi();
        test_stuck_done();
        test_abort();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
